reg_file: RTL and testbench

//  Parametrised multi-register storage for the single-cycle datapath.

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_if.sv | 31 +++
 rtl/reg_file_rport.sv | 35 +++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file slice.
// The optional write-through read path is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int ZERO_ADDR     = 0;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_file_if.sv
// Write/read bus of the register file: one write port and three read ports.
// Decode/writeback side uses the master modport, the register file uses the slave modport.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              WE;
    logic [ADDR_W-1:0] WA;
    logic [WIDTH-1:0]  WD;
    logic [ADDR_W-1:0] RA1;
    logic [WIDTH-1:0]  RD1;
    logic [ADDR_W-1:0] RA2;
    logic [WIDTH-1:0]  RD2;
    logic [ADDR_W-1:0] RA3;
    logic [WIDTH-1:0]  RD3;

    modport master (
        output WE, WA, WD, RA1, RA2, RA3,
        input  RD1, RD2, RD3
    );

    modport slave (
        input  WE, WA, WD, RA1, RA2, RA3,
        output RD1, RD2, RD3
    );

endinterface

// File: rtl/reg_file_rport.sv
// One combinational read port: address mux, register-0 override and, when
// REG_FILE_BYPASS_EN is defined, same-cycle forwarding of the write data.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0]  regs [DEPTH],
    input  logic [ADDR_W-1:0] ra,
    output logic [WIDTH-1:0]  rd
`ifdef REG_FILE_BYPASS_EN
    ,
    input  logic              wr_fire,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd
`endif
);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    always_comb begin
        rd = regs[ra];
`ifdef REG_FILE_BYPASS_EN
        if (wr_fire && (ra == wa)) begin
            rd = wd;
        end
`endif
        // Register 0 wins over both storage and forwarding.
        if (ra == ZERO_A) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file, one write port, three combinational read ports, reg 0 reads zero.
// Defining REG_FILE_BYPASS_EN forwards the pending write data to matching read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        CLK,
    input  logic        RST,
    reg_file_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    // Exact address width is what rules out out-of-range reads.
    if ((DEPTH < 2) || ((1 << ADDR_W) != DEPTH)) begin : g_depth_chk
        $error("reg_file: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;

    assign wr_en = bus.WE && (bus.WA != ZERO_A);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.WA] <= bus.WD;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic wr_fire;
    assign wr_fire = wr_en && !RST;
`endif

    reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rport1 (
        .regs    (regs),
        .ra      (bus.RA1),
        .rd      (bus.RD1)
`ifdef REG_FILE_BYPASS_EN
        ,
        .wr_fire (wr_fire),
        .wa      (bus.WA),
        .wd      (bus.WD)
`endif
    );

    reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rport2 (
        .regs    (regs),
        .ra      (bus.RA2),
        .rd      (bus.RD2)
`ifdef REG_FILE_BYPASS_EN
        ,
        .wr_fire (wr_fire),
        .wa      (bus.WA),
        .wd      (bus.WD)
`endif
    );

    reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rport3 (
        .regs    (regs),
        .ra      (bus.RA3),
        .rd      (bus.RD3)
`ifdef REG_FILE_BYPASS_EN
        ,
        .wr_fire (wr_fire),
        .wa      (bus.WA),
        .wd      (bus.WD)
`endif
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_file_if #(.WIDTH(32), .DEPTH(32)) bus ();

    reg_file #(.WIDTH(32), .DEPTH(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WE  = 1'b0;
        bus.WA  = '0;
        bus.WD  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        bus.RA1 = 5'd0;
        bus.RA2 = 5'd5;
        bus.RA3 = 5'd31;
        #1;
        vectors++;
        if (bus.RD1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd1 got %h want %h", bus.RD1, 32'h0);
        end
        vectors++;
        if (bus.RD2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd2 got %h want %h", bus.RD2, 32'h0);
        end
        vectors++;
        if (bus.RD3 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd3 got %h want %h", bus.RD3, 32'h0);
        end
    endtask

    task automatic test_write_read();
        bus.WE = 1'b1;
        bus.WA = 5'd5;
        bus.WD = 32'hDEADBEEF;
        tick();
        idle();
        bus.RA1 = 5'd5;
        bus.RA2 = 5'd6;
        bus.RA3 = 5'd5;
        #1;
        vectors++;
        if (bus.RD1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_rd1 got %h want %h", bus.RD1, 32'hDEADBEEF);
        end
        vectors++;
        if (bus.RD2 !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_rd2_other got %h want %h", bus.RD2, 32'h0);
        end
        vectors++;
        if (bus.RD3 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_rd3 got %h want %h", bus.RD3, 32'hDEADBEEF);
        end
    endtask

    task automatic test_zero_reg();
        bus.WE  = 1'b1;
        bus.WA  = 5'd0;
        bus.WD  = 32'hFFFFFFFF;
        bus.RA1 = 5'd0;
        #1;
        vectors++;
        if (bus.RD1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_pre_edge got %h want %h", bus.RD1, 32'h0);
        end
        tick();
        idle();
        bus.RA1 = 5'd0;
        bus.RA2 = 5'd0;
        #1;
        vectors++;
        if (bus.RD1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_rd1 got %h want %h", bus.RD1, 32'h0);
        end
        vectors++;
        if (bus.RD2 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_rd2 got %h want %h", bus.RD2, 32'h0);
        end
    endtask

    task automatic test_same_cycle();
        word_t exp_pre;
        bus.WE = 1'b1;
        bus.WA = 5'd7;
        bus.WD = 32'h000000A5;
        tick();
        bus.WD  = 32'h12345678;
        bus.RA1 = 5'd7;
        bus.RA3 = 5'd7;
        bus.RA2 = 5'd8;
        #1;
`ifdef REG_FILE_BYPASS_EN
        exp_pre = 32'h12345678;
`else
        exp_pre = 32'h000000A5;
`endif
        vectors++;
        if (bus.RD1 !== exp_pre) begin
            miscompares++;
            $display("FAIL same_cycle_rd1 got %h want %h", bus.RD1, exp_pre);
        end
        vectors++;
        if (bus.RD3 !== exp_pre) begin
            miscompares++;
            $display("FAIL same_cycle_rd3 got %h want %h", bus.RD3, exp_pre);
        end
        vectors++;
        if (bus.RD2 !== 32'h0) begin
            miscompares++;
            $display("FAIL same_cycle_rd2_other got %h want %h", bus.RD2, 32'h0);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus.RD1 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL same_cycle_post got %h want %h", bus.RD1, 32'h12345678);
        end
    endtask

    task automatic test_no_write();
        bus.WE  = 1'b0;
        bus.WA  = 5'd9;
        bus.WD  = 32'hCAFEF00D;
        bus.RA1 = 5'd9;
        tick();
        #1;
        vectors++;
        if (bus.RD1 !== 32'h0) begin
            miscompares++;
            $display("FAIL we_low_ignored got %h want %h", bus.RD1, 32'h0);
        end
    endtask

    task automatic test_reset_vs_write();
        bus.WE = 1'b1;
        bus.WA = 5'd3;
        bus.WD = 32'h00000077;
        tick();
        rst     = 1'b1;
        bus.WD  = 32'h00000055;
        bus.RA1 = 5'd3;
        bus.RA2 = 5'd5;
        #1;
        vectors++;
        if (bus.RD1 !== 32'h00000077) begin
            miscompares++;
            $display("FAIL rst_write_pre got %h want %h", bus.RD1, 32'h00000077);
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        vectors++;
        if (bus.RD1 !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_wins_rd1 got %h want %h", bus.RD1, 32'h0);
        end
        vectors++;
        if (bus.RD2 !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_clears_r5 got %h want %h", bus.RD2, 32'h0);
        end
    endtask

    task automatic test_sweep();
        word_t e1, e2, e3;
        logic [4:0] a1, a2, a3;
        for (int i = 1; i < 32; i++) begin
            bus.WE = 1'b1;
            bus.WA = 5'(i);
            bus.WD = 32'(i) * 32'h01010101;
            tick();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'((i + 1) % 32);
            a3 = 5'((i + 2) % 32);
            bus.RA1 = a1;
            bus.RA2 = a2;
            bus.RA3 = a3;
            e1 = {4{3'b000, a1}};
            e2 = {4{3'b000, a2}};
            e3 = {4{3'b000, a3}};
            #1;
            vectors++;
            if (bus.RD1 !== e1) begin
                miscompares++;
                $display("FAIL sweep_rd1 a=%0d got %h want %h", a1, bus.RD1, e1);
            end
            vectors++;
            if (bus.RD2 !== e2) begin
                miscompares++;
                $display("FAIL sweep_rd2 a=%0d got %h want %h", a2, bus.RD2, e2);
            end
            vectors++;
            if (bus.RD3 !== e3) begin
                miscompares++;
                $display("FAIL sweep_rd3 a=%0d got %h want %h", a3, bus.RD3, e3);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.WE = 1'b1;
        bus.WA = 5'd10;
        bus.WD = 32'h11112222;
        tick();
        bus.WA = 5'd10;
        bus.WD = 32'h33334444;
        tick();
        bus.WA = 5'd11;
        bus.WD = 32'h55556666;
        tick();
        idle();
        bus.RA1 = 5'd10;
        bus.RA2 = 5'd11;
        bus.RA3 = 5'd10;
        #1;
        vectors++;
        if (bus.RD1 !== 32'h33334444) begin
            miscompares++;
            $display("FAIL b2b_overwrite got %h want %h", bus.RD1, 32'h33334444);
        end
        vectors++;
        if (bus.RD2 !== 32'h55556666) begin
            miscompares++;
            $display("FAIL b2b_next got %h want %h", bus.RD2, 32'h55556666);
        end
        vectors++;
        if (bus.RD3 !== 32'h33334444) begin
            miscompares++;
            $display("FAIL b2b_rd3 got %h want %h", bus.RD3, 32'h33334444);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle();
        bus.RA1 = '0;
        bus.RA2 = '0;
        bus.RA3 = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_cycle();
        test_no_write();
        test_reset_vs_write();
        test_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
